fifo_wr_arbiter: RTL
====================

// Module: fifo_wr_arbiter
// PURPOSE
//  Shares the single write port of the asynchronous FIFO between NUM_REQ requesters.
//  Round-robin grant with burst ownership: the winner keeps the port until it signals last or hits BURST_MAX beats.
//  Lives entirely in the FIFO write-clock domain; drives wr_en/wr_data and obeys o_fifo_full.
// PARAMETERS
//  NUM_REQ    4   number of requesters (2..8)
//  DATAWIDTH  8   FIFO word width; must match the FIFO
//  BURST_MAX  16  max beats per grant before forced release (1..255)
// PORTS
//  wr_clk        in   1                  write-side clock (single clock for this block)
//  wr_rst        in   1                  reset, asynchronous assert, active-low (0 = reset)
//  req_valid     in   NUM_REQ            per-requester word valid
//  req_last      in   NUM_REQ            per-requester last beat of burst (sampled with valid)
//  req_data      in   NUM_REQ*DATAWIDTH  flat data bus, requester i at [i*DATAWIDTH +: DATAWIDTH]
//  req_ready     out  NUM_REQ            beat accepted when valid & ready
//  o_fifo_full   in   1                  full flag from the FIFO
//  wr_en         out  1                  FIFO write enable
//  wr_data       out  DATAWIDTH          FIFO write data
//  grant_id      out  $clog2(NUM_REQ)    current/last owner index
//  busy          out  1                  high in GRANT state
// BEHAVIOUR
//  States: IDLE, GRANT (2-state FSM, registered).
//  Reset: state=IDLE, grant_id=NUM_REQ-1 (so requester 0 wins first), beat_cnt=0; wr_en=0, req_ready=0, busy=0.
//  IDLE: if any req_valid, pick first valid index searching grant_id+1, +2, ... modulo NUM_REQ; register it
//   into grant_id, go GRANT next cycle. No valid -> stay IDLE. Arbitration costs 1 cycle per burst.
//  GRANT: req_ready[grant_id] = ~o_fifo_full (combinational); all other ready bits 0.
//   accept = req_valid[grant_id] & req_ready[grant_id]; wr_en = accept; wr_data = req_data slice of grant_id.
//   Zero latency: a beat reaches the FIFO in the same cycle it is accepted.
//   On accept: beat_cnt++; if req_last[grant_id] or beat_cnt==BURST_MAX-1 -> IDLE, beat_cnt=0.
//   Owner dropping valid mid-burst: keep GRANT, no write, no count (owner holds the port).
//  o_fifo_full high: ready low, no write, beat_cnt frozen, state held; resumes the cycle full drops.
//  Requester valid in IDLE is never acked in IDLE (ready=0 outside GRANT).
//  grant_id wraps NUM_REQ-1 -> 0; unchanged while in IDLE until a new grant.
//  Reset assertion mid-burst: immediately IDLE, wr_en=0; partial burst is not resumed.
//  wr_en never asserts while o_fifo_full=1 (hard invariant).
// CONFIGURATION
//  FIFO_WR_ARB_PRIO0_EN defined: in IDLE, requester 0 wins whenever req_valid[0]=1, regardless of RR
//   pointer; other requesters keep round-robin among themselves. Bursts are never pre-empted.
//  Undefined: pure round-robin as above, requester 0 has no special treatment.
// STRUCTURE
//  fifo_arb_pkg: state enum {ARB_IDLE, ARB_GRANT}, function for grant-index width, BURST count width const.
//  Sub-module rr_pick: combinational round-robin picker (req vector + last pointer -> one-hot + index + any).
//  Top holds FSM, beat counter, grant register, output mux.
// TESTING
//  1. Reset then req_valid=4'b0001, 3 beats, last on 3rd -> grant_id=0, wr_en high 3 cycles, data in order, back to IDLE.
//  2. req_valid=4'b1111 all with 1-beat bursts -> grant order 0,1,2,3,0; one IDLE cycle between bursts.
//  3. Requester 2 sends 20 beats without last, BURST_MAX=16 -> forced release after beat 16; requester 2 regrants only after others served.
//  4. o_fifo_full raised for 5 cycles mid-burst -> wr_en=0, req_ready=0, beat_cnt frozen; burst completes after full drops.
//  5. wr_rst pulled low during beat 4 of a burst -> wr_en=0 same cycle, state IDLE, grant_id=NUM_REQ-1 after release.
//  6. With FIFO_WR_ARB_PRIO0_EN, req_valid=4'b0110 then req 0 joins -> req 0 granted at next IDLE ahead of pending 1/2.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO write-port arbiter.
// Optional feature macro used by the arbiter: FIFO_WR_ARB_PRIO0_EN.
package fifo_arb_pkg;

    // Two-state arbiter FSM: arbitrate in IDLE, stream a burst in GRANT.
    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

    // Beat counter width; covers BURST_MAX up to 255.
    localparam int unsigned BEAT_CNT_W = 8;

    // Width of a requester index; never narrower than one bit.
    function automatic int unsigned grant_idx_w(input int unsigned num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: scans the request vector starting
// just after last_ptr (wrapping) and reports the first requester found.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = grant_idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_ptr,
    output logic [N-1:0]  pick_onehot,
    output logic [IW-1:0] pick_idx,
    output logic          pick_any
);

    // Candidate k is (last_ptr + k) mod N; the lowest k with a request wins.
    always_comb begin
        pick_onehot = '0;
        pick_idx    = '0;
        pick_any    = 1'b0;
        for (int k = 1; k <= N; k++) begin
            for (int j = 0; j < N; j++) begin
                if (!pick_any && req[j] && (j == ((int'(last_ptr) + k) % N))) begin
                    pick_any       = 1'b1;
                    pick_idx       = IW'(j);
                    pick_onehot[j] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the FIFO write port between NUM_REQ
// requesters with burst ownership (until last or BURST_MAX beats).
// Optional macro FIFO_WR_ARB_PRIO0_EN: requester 0 wins every arbitration
// it takes part in; the others keep round-robin among themselves.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter  int NUM_REQ   = 4,
    parameter  int DATAWIDTH = 8,
    parameter  int BURST_MAX = 16,
    localparam int IW        = grant_idx_w(NUM_REQ)
) (
    input  logic                           wr_clk,
    input  logic                           wr_rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ-1:0]             req_last,
    input  logic [NUM_REQ*DATAWIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic                           o_fifo_full,
    output logic                           wr_en,
    output logic [DATAWIDTH-1:0]           wr_data,
    output logic [IW-1:0]                  grant_id,
    output logic                           busy
);

    arb_state_e              state_q, state_d;
    logic [IW-1:0]           grant_id_q, grant_id_d;
    logic [BEAT_CNT_W-1:0]   beat_cnt_q, beat_cnt_d;

    logic [DATAWIDTH-1:0]    req_data_arr [NUM_REQ];
    logic [NUM_REQ-1:0]      rr_req;
    logic [NUM_REQ-1:0]      unused_rr_onehot;
    logic [IW-1:0]           rr_idx;
    logic                    rr_any;
    logic [IW-1:0]           win_idx;
    logic                    win_any;
    logic                    accept;
    logic                    end_of_burst;

    // Unpack the flat data bus into one word per requester.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
            assign req_data_arr[gi] = req_data[gi*DATAWIDTH +: DATAWIDTH];
        end
    endgenerate

`ifdef FIFO_WR_ARB_PRIO0_EN
    // Requester 0 is handled by the priority override, not by the rotation.
    assign rr_req = req_valid & ~NUM_REQ'(1);
`else
    assign rr_req = req_valid;
`endif

    rr_pick #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_rr_pick (
        .req         (rr_req),
        .last_ptr    (grant_id_q),
        .pick_onehot (unused_rr_onehot),
        .pick_idx    (rr_idx),
        .pick_any    (rr_any)
    );

    // Winner of the next arbitration, with optional requester-0 override.
    always_comb begin
        win_any = rr_any;
        win_idx = rr_idx;
`ifdef FIFO_WR_ARB_PRIO0_EN
        if (req_valid[0]) begin
            win_any = 1'b1;
            win_idx = '0;
        end
`endif
    end

    // Beat acceptance: only the owner, only in GRANT, never into a full FIFO.
    assign accept       = (state_q == ARB_GRANT) && req_valid[grant_id_q] && !o_fifo_full;
    assign end_of_burst = req_last[grant_id_q] ||
                          (beat_cnt_q == BEAT_CNT_W'(BURST_MAX - 1));

    // Next-state logic for the FSM, grant pointer and beat counter.
    always_comb begin
        state_d    = state_q;
        grant_id_d = grant_id_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            ARB_IDLE: begin
                if (win_any) begin
                    state_d    = ARB_GRANT;
                    grant_id_d = win_idx;
                    beat_cnt_d = '0;
                end
            end
            ARB_GRANT: begin
                // A stalled or silent owner keeps the port with the count frozen.
                if (accept) begin
                    if (end_of_burst) begin
                        state_d    = ARB_IDLE;
                        beat_cnt_d = '0;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d    = ARB_IDLE;
                beat_cnt_d = '0;
            end
        endcase
    end

    // State registers; reset points the grant at the last requester so
    // requester 0 is first in line.
    always_ff @(posedge wr_clk or negedge wr_rst) begin
        if (!wr_rst) begin
            state_q    <= ARB_IDLE;
            grant_id_q <= IW'(NUM_REQ - 1);
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_id_q <= grant_id_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // Ready goes only to the owner, and only while the FIFO has room.
    always_comb begin
        req_ready = '0;
        if ((state_q == ARB_GRANT) && !o_fifo_full) begin
            req_ready[grant_id_q] = 1'b1;
        end
    end

    assign wr_en    = accept;
    assign wr_data  = req_data_arr[grant_id_q];
    assign grant_id = grant_id_q;
    assign busy     = (state_q == ARB_GRANT);

endmodule
